// File: rtl/assembler_sequencer_pkg.sv
// Shared types and character constants for the assembler sequencer.
package assembler_sequencer_pkg;

    // Which pass the downstream assembler is being fed.
    typedef enum logic [1:0] {
        ASM_IDLE            = 2'd0,
        PC_MAPPING          = 2'd1,
        INSTRUCTION_MAPPING = 2'd2
    } assembler_state_t;

    // A NUL byte ends a text line early.
    localparam logic [7:0] CHAR_EOL   = 8'h00;
    // A space is fed after every line so the last token is always closed.
    localparam logic [7:0] CHAR_DELIM = 8'h20;

endpackage

// File: rtl/assembler_sequencer_imem_writer.sv
// Captures assembled words and writes them to sequential instruction memory
// addresses, one cycle after capture, with a saturating word counter.
module imem_writer #(
    parameter int NUMBER_LINES = 256,
    parameter int LINE_W       = 8,
    parameter int CNT_W        = 9
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clear,
    input  logic              i_capture,
    input  logic [31:0]       i_instruction,
    output logic              o_we,
    output logic [LINE_W-1:0] o_addr,
    output logic [31:0]       o_data,
    output logic [CNT_W-1:0]  o_count
);

    logic              r_we;
    logic [LINE_W-1:0] r_addr;
    logic [31:0]       r_data;
    logic [CNT_W-1:0]  r_count;
    logic              w_room;

    // Once NUMBER_LINES words are stored, further captures are dropped.
    assign w_room = (r_count < CNT_W'(NUMBER_LINES));

    // Capture register and counter; the write strobe is a one-cycle pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_count <= '0;
        end else begin
            r_we <= 1'b0;
            if (i_clear) begin
                r_count <= '0;
            end else if (i_capture && w_room) begin
                r_we    <= 1'b1;
                r_addr  <= r_count[LINE_W-1:0];
                r_data  <= i_instruction;
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    assign o_we    = r_we;
    assign o_addr  = r_addr;
    assign o_data  = r_data;
    assign o_count = r_count;

endmodule

// File: rtl/assembler_sequencer.sv
// Two-pass assembler sequencer: streams line-organised text from a BRAM into
// the assembler one character at a time (label pass, then instruction pass)
// and stores every instruction emitted during the second pass.
//
// Interface semantics: there is no back-pressure anywhere. new_line and
// new_character are single-cycle valid pulses; incoming_character is only
// meaningful while new_character is high. asm_new_instruction is a
// single-cycle valid from the assembler with asm_instruction alongside it.
// imem_we is a single-cycle write valid carrying imem_addr/imem_data.
module assembler_sequencer
    import assembler_sequencer_pkg::*;
#(
    parameter  int CHAR_PER_LINE = 64,
    parameter  int NUMBER_LINES  = 256,
    parameter  int BRAM_LATENCY  = 2,
    parameter  int DRAIN_CYCLES  = 4,
    localparam int LINE_W        = $clog2(NUMBER_LINES),
    localparam int CHAR_W        = $clog2(CHAR_PER_LINE),
    localparam int CNT_W         = $clog2(NUMBER_LINES) + 1,
    localparam int ADDR_W        = $clog2(NUMBER_LINES * CHAR_PER_LINE)
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              start_in,
    input  logic [CNT_W-1:0]  num_lines_in,
    output logic [ADDR_W-1:0] text_addr,
    input  logic [7:0]        text_data,
    output assembler_state_t  assembler_state,
    output logic              new_line,
    output logic              new_character,
    output logic [LINE_W-1:0] line_count,
    output logic [CHAR_W-1:0] char_count,
    output logic [7:0]        incoming_character,
    input  logic              asm_error,
    input  logic              asm_new_instruction,
    input  logic [31:0]       asm_instruction,
    output logic              imem_we,
    output logic [LINE_W-1:0] imem_addr,
    output logic [31:0]       imem_data,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [LINE_W-1:0] error_line,
    output logic [CNT_W-1:0]  inst_count,
    output logic [3:0]        o_dbg_state
);

    localparam int WAIT_MAX = (BRAM_LATENCY > DRAIN_CYCLES) ? BRAM_LATENCY : DRAIN_CYCLES;
    localparam int WAIT_W   = $clog2(WAIT_MAX + 1);

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_LINE_START = 4'd1,
        S_FETCH      = 4'd2,
        S_WAIT_DATA  = 4'd3,
        S_EMIT       = 4'd4,
        S_EMIT_TERM  = 4'd5,
        S_DRAIN      = 4'd6,
        S_NEXT_LINE  = 4'd7,
        S_FINISH     = 4'd8,
        S_ERROR      = 4'd9
    } seq_state_t;

    seq_state_t       r_state,      w_state_nxt;
    logic [LINE_W-1:0] r_line,      w_line_nxt;
    logic [CHAR_W-1:0] r_char,      w_char_nxt;
    logic [WAIT_W-1:0] r_wait,      w_wait_nxt;
    logic [CNT_W-1:0]  r_num_lines, w_num_lines_nxt;
    logic              r_busy,      w_busy_nxt;
    logic              r_done,      w_done_nxt;
    logic              r_error,     w_error_nxt;
    logic [LINE_W-1:0] r_error_line, w_error_line_nxt;
    assembler_state_t  r_asm_state, w_asm_state_nxt;

    logic              w_clear;
    logic              w_err_take;
    logic              w_capture;
    logic              w_more_lines;
    logic [ADDR_W-1:0] w_text_addr;

    // Text address is always line*CHAR_PER_LINE + char of the current position.
    assign w_text_addr  = ADDR_W'(r_line) * ADDR_W'(CHAR_PER_LINE) + ADDR_W'(r_char);
    assign w_more_lines = (CNT_W'(r_line) + CNT_W'(1)) < r_num_lines;

    // FSM state register.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath registers that follow the FSM's next-value decisions.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_line       <= '0;
            r_char       <= '0;
            r_wait       <= '0;
            r_num_lines  <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_error_line <= '0;
            r_asm_state  <= ASM_IDLE;
        end else begin
            r_line       <= w_line_nxt;
            r_char       <= w_char_nxt;
            r_wait       <= w_wait_nxt;
            r_num_lines  <= w_num_lines_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_error      <= w_error_nxt;
            r_error_line <= w_error_line_nxt;
            r_asm_state  <= w_asm_state_nxt;
        end
    end

    // Next-state, next-datapath values and the character/line pulses.
    always_comb begin
        w_state_nxt        = r_state;
        w_line_nxt         = r_line;
        w_char_nxt         = r_char;
        w_wait_nxt         = r_wait;
        w_num_lines_nxt    = r_num_lines;
        w_busy_nxt         = r_busy;
        w_done_nxt         = r_done;
        w_error_nxt        = r_error;
        w_error_line_nxt   = r_error_line;
        w_asm_state_nxt    = r_asm_state;
        w_clear            = 1'b0;
        w_err_take         = 1'b0;
        new_line           = 1'b0;
        new_character      = 1'b0;
        incoming_character = 8'h00;

        case (r_state)
            S_IDLE: begin
                if (start_in) begin
                    // Line count is clamped so the line counter cannot wrap.
                    w_num_lines_nxt = (num_lines_in > CNT_W'(NUMBER_LINES)) ?
                                      CNT_W'(NUMBER_LINES) : num_lines_in;
                    w_clear         = 1'b1;
                    w_done_nxt      = 1'b0;
                    w_error_nxt     = 1'b0;
                    w_busy_nxt      = 1'b1;
                    w_asm_state_nxt = PC_MAPPING;
                    w_line_nxt      = '0;
                    w_char_nxt      = '0;
                    w_state_nxt     = (num_lines_in == '0) ? S_FINISH : S_LINE_START;
                end
            end

            S_LINE_START: begin
                new_line    = 1'b1;
                w_char_nxt  = '0;
                w_state_nxt = S_FETCH;
            end

            S_FETCH: begin
                w_wait_nxt  = '0;
                w_state_nxt = S_WAIT_DATA;
            end

            S_WAIT_DATA: begin
                if (r_wait == WAIT_W'(BRAM_LATENCY - 1)) begin
                    w_state_nxt = S_EMIT;
                end else begin
                    w_wait_nxt = r_wait + WAIT_W'(1);
                end
            end

            S_EMIT: begin
                if (text_data == CHAR_EOL) begin
                    w_state_nxt = S_EMIT_TERM;
                end else begin
                    new_character      = 1'b1;
                    incoming_character = text_data;
                    // The last column ends the line without reading past it.
                    if (r_char == CHAR_W'(CHAR_PER_LINE - 1)) begin
                        w_state_nxt = S_EMIT_TERM;
                    end else begin
                        w_char_nxt  = r_char + CHAR_W'(1);
                        w_state_nxt = S_FETCH;
                    end
                end
            end

            S_EMIT_TERM: begin
                new_character      = 1'b1;
                incoming_character = CHAR_DELIM;
                w_wait_nxt         = '0;
                w_state_nxt        = S_DRAIN;
            end

            S_DRAIN: begin
                if (r_wait == WAIT_W'(DRAIN_CYCLES - 1)) begin
                    w_state_nxt = S_NEXT_LINE;
                end else begin
                    w_wait_nxt = r_wait + WAIT_W'(1);
                end
            end

            S_NEXT_LINE: begin
                if (w_more_lines) begin
                    w_line_nxt  = r_line + LINE_W'(1);
                    w_state_nxt = S_LINE_START;
                end else if (r_asm_state == PC_MAPPING) begin
                    w_line_nxt      = '0;
                    w_asm_state_nxt = INSTRUCTION_MAPPING;
                    w_state_nxt     = S_LINE_START;
                end else begin
                    w_state_nxt = S_FINISH;
                end
            end

            S_FINISH: begin
                w_asm_state_nxt = ASM_IDLE;
                w_busy_nxt      = 1'b0;
                w_done_nxt      = 1'b1;
                w_state_nxt     = S_IDLE;
            end

            S_ERROR: begin
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // An assembler error aborts the run from any active state.
        if (asm_error && (r_state != S_IDLE) && (r_state != S_FINISH) &&
            (r_state != S_ERROR)) begin
            w_err_take       = 1'b1;
            w_error_line_nxt = r_line;
            w_busy_nxt       = 1'b0;
            w_error_nxt      = 1'b1;
            w_asm_state_nxt  = ASM_IDLE;
            w_state_nxt      = S_ERROR;
        end
    end

    // Only second-pass instructions are stored; an error in the same cycle wins.
    assign w_capture = (r_asm_state == INSTRUCTION_MAPPING) && asm_new_instruction && !w_err_take;

    imem_writer #(
        .NUMBER_LINES (NUMBER_LINES),
        .LINE_W       (LINE_W),
        .CNT_W        (CNT_W)
    ) u_imem_writer (
        .i_clk         (clk_in),
        .i_rst_n       (rst_in),
        .i_clear       (w_clear),
        .i_capture     (w_capture),
        .i_instruction (asm_instruction),
        .o_we          (imem_we),
        .o_addr        (imem_addr),
        .o_data        (imem_data),
        .o_count       (inst_count)
    );

    assign text_addr       = w_text_addr;
    assign assembler_state = r_asm_state;
    assign line_count      = r_line;
    assign char_count      = r_char;
    assign busy            = r_busy;
    assign done            = r_done;
    assign error           = r_error;
    assign error_line      = r_error_line;
    assign o_dbg_state     = r_state;

endmodule
